// File: rtl/alnpc_wr_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : alnpc_wr_queue_if
// Purpose  : Bus bundle between the execute-lane writeback producer and the
//            active-list next-PC write queue. Optional commit-read
//            forwarding signals are present when ALNPC_WRQ_FWD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface alnpc_wr_queue_if #(
   parameter int LANES = 4,
   parameter int INDEX = 7,
   parameter int WIDTH = 32,
   parameter int CNTW  = 4
);
   logic                   flush_i;
   logic [LANES-1:0]       lane_vld_i;
   logic [LANES*INDEX-1:0] lane_addr_i;
   logic [LANES*WIDTH-1:0] lane_data_i;
   logic                   stall_o;
   logic [INDEX-1:0]       addr0wr_o;
   logic [WIDTH-1:0]       data0wr_o;
   logic                   we0_o;
   logic [CNTW-1:0]        occ_o;
   logic                   ovf_o;
`ifdef ALNPC_WRQ_FWD_EN
   logic [INDEX-1:0]       rd_addr_i;
   logic [WIDTH-1:0]       rd_ram_i;
   logic [WIDTH-1:0]       rd_data_o;
   logic                   rd_hit_o;

   modport master (
      output flush_i, lane_vld_i, lane_addr_i, lane_data_i, rd_addr_i, rd_ram_i,
      input  stall_o, addr0wr_o, data0wr_o, we0_o, occ_o, ovf_o, rd_data_o, rd_hit_o
   );
   modport slave (
      input  flush_i, lane_vld_i, lane_addr_i, lane_data_i, rd_addr_i, rd_ram_i,
      output stall_o, addr0wr_o, data0wr_o, we0_o, occ_o, ovf_o, rd_data_o, rd_hit_o
   );
`else
   modport master (
      output flush_i, lane_vld_i, lane_addr_i, lane_data_i,
      input  stall_o, addr0wr_o, data0wr_o, we0_o, occ_o, ovf_o
   );
   modport slave (
      input  flush_i, lane_vld_i, lane_addr_i, lane_data_i,
      output stall_o, addr0wr_o, data0wr_o, we0_o, occ_o, ovf_o
   );
`endif
endinterface
`default_nettype wire

// File: rtl/alnpc_wr_queue.sv
`default_nettype none
// ============================================================================
// Module   : alnpc_wr_queue
// Purpose  : Write-side front end of the active-list next-PC RAM. Compacts up
//            to LANES writebacks per cycle into a circular queue and drains
//            one entry per cycle into the RAM's single write port.
//            Optional feature macro: ALNPC_WRQ_FWD_EN adds a combinational
//            commit-read forwarding path (youngest queued match wins).
// Revision : 1.0 - initial release
// ============================================================================
module alnpc_wr_queue #(
   parameter int LANES = 4,
   parameter int INDEX = 7,
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int CNTW  = 4
) (
   input  wire logic       clk,
   input  wire logic       reset,
   alnpc_wr_queue_if.slave bus
);
   localparam int              c_PTRW      = $clog2(DEPTH);
   // Stall whenever fewer than LANES free slots remain, i.e. occ > DEPTH-LANES.
   localparam logic [CNTW-1:0] c_STALL_THR = CNTW'(DEPTH - LANES);

   // Entry storage is intentionally not reset; it is only observed via head.
   logic [INDEX-1:0]  r_addr_mem [DEPTH];
   logic [WIDTH-1:0]  r_data_mem [DEPTH];
   logic [c_PTRW-1:0] r_head;
   logic [c_PTRW-1:0] r_tail;
   logic [CNTW-1:0]   r_occ;
   logic              r_ovf;

   logic              w_stall;
   logic              w_deq;
   logic [LANES-1:0]  w_acc;
   logic [CNTW-1:0]   w_nacc;
   logic [c_PTRW-1:0] w_slot [LANES];

   // Stall and dequeue depend on registered occupancy only; lanes are taken
   // only when not stalled and not flushing.
   always_comb begin
      w_stall = (r_occ > c_STALL_THR);
      w_deq   = (r_occ != '0);
      w_acc   = bus.lane_vld_i & {LANES{~w_stall & ~bus.flush_i}};
   end

   // Lane compaction: each accepted lane lands at tail + (accepted lanes below it).
   always_comb begin
      w_nacc = '0;
      for (int i = 0; i < LANES; i++) begin
         w_slot[i] = r_tail + c_PTRW'(w_nacc);
         if (w_acc[i]) begin
            w_nacc = w_nacc + CNTW'(1);
         end
      end
   end

   // Entry storage write; compacted slots are distinct so lanes never collide.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (w_acc[i]) begin
            r_addr_mem[w_slot[i]] <= bus.lane_addr_i[i*INDEX +: INDEX];
            r_data_mem[w_slot[i]] <= bus.lane_data_i[i*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer/occupancy/overflow state; flush empties the queue and beats lanes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_stall && (bus.lane_vld_i != '0)) begin
            r_ovf <= 1'b1;
         end
         if (bus.flush_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
         end else begin
            r_tail <= r_tail + c_PTRW'(w_nacc);
            if (w_deq) begin
               r_head <= r_head + c_PTRW'(1);
            end
            r_occ <= r_occ + w_nacc - CNTW'(w_deq);
         end
      end
   end

   assign bus.stall_o   = w_stall;
   assign bus.we0_o     = w_deq;
   assign bus.occ_o     = r_occ;
   assign bus.ovf_o     = r_ovf;
   assign bus.addr0wr_o = r_addr_mem[r_head];
   assign bus.data0wr_o = r_data_mem[r_head];

`ifdef ALNPC_WRQ_FWD_EN
   logic [c_PTRW-1:0] w_fidx;

   // Forwarding search, oldest to youngest, so the last match is the youngest.
   always_comb begin
      w_fidx        = '0;
      bus.rd_data_o = bus.rd_ram_i;
      bus.rd_hit_o  = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         w_fidx = r_head + c_PTRW'(k);
         if ((CNTW'(k) < r_occ) && (r_addr_mem[w_fidx] == bus.rd_addr_i)) begin
            bus.rd_data_o = r_data_mem[w_fidx];
            bus.rd_hit_o  = 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alnpc_wr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alnpc_wr_queue
// Purpose  : Self-checking bench for alnpc_wr_queue against a queue-based
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alnpc_wr_queue;
   localparam int LANES = 4;
   localparam int INDEX = 7;
   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int CNTW  = 4;

   typedef struct packed {
      logic [INDEX-1:0] a;
      logic [WIDTH-1:0] d;
   } ent_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   ent_t mq[$];        // model queue contents, head first
   ent_t m_stream[$];  // model write-port stream
   ent_t d_stream[$];  // observed write-port stream
   ent_t sent[$];      // entries the bench expects to be accepted
   bit   m_ovf;

   alnpc_wr_queue_if #(.LANES(LANES), .INDEX(INDEX), .WIDTH(WIDTH), .CNTW(CNTW)) bus ();

   alnpc_wr_queue #(.LANES(LANES), .INDEX(INDEX), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $fatal(1, "watchdog");
   end

   task automatic set_lane(input int i, input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d);
      bus.lane_addr_i[i*INDEX +: INDEX] = a;
      bus.lane_data_i[i*WIDTH +: WIDTH] = d;
   endtask

   // Reference model step using the inputs present before the edge.
   task automatic model_edge();
      int   sz;
      bit   st;
      ent_t e;
      sz = mq.size();
      st = (DEPTH - sz) < LANES;
      if (sz > 0) m_stream.push_back(mq.pop_front());
      if (st && (bus.lane_vld_i != '0)) m_ovf = 1'b1;
      if (bus.flush_i) mq.delete();
      else if (!st) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.lane_vld_i[i]) begin
               e.a = bus.lane_addr_i[i*INDEX +: INDEX];
               e.d = bus.lane_data_i[i*WIDTH +: WIDTH];
               mq.push_back(e);
            end
         end
      end
   endtask

   task automatic tick();
      ent_t e;
      if (bus.we0_o === 1'b1) begin
         e.a = bus.addr0wr_o;
         e.d = bus.data0wr_o;
         d_stream.push_back(e);
      end
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.lane_vld_i = '0;
      bus.flush_i    = 1'b0;
      for (int c = 0; c < 4 * DEPTH && mq.size() > 0; c++) tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.flush_i = 1'b0;
      bus.lane_vld_i = '0;
      bus.lane_addr_i = '0;
      bus.lane_data_i = '0;
`ifdef ALNPC_WRQ_FWD_EN
      bus.rd_addr_i = '0;
      bus.rd_ram_i  = '0;
`endif
      mq.delete();
      m_ovf = 1'b0;
      #12;
      checks++;
      if (bus.we0_o !== 1'b0 || bus.occ_o !== '0 || bus.stall_o !== 1'b0 || bus.ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: we0=%b occ=%0d stall=%b ovf=%b required 0,0,0,0",
                  bus.we0_o, bus.occ_o, bus.stall_o, bus.ovf_o);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (bus.we0_o !== 1'b0 || bus.occ_o !== '0 || bus.stall_o !== 1'b0 || bus.ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: we0=%b occ=%0d stall=%b ovf=%b required 0,0,0,0",
                     c, bus.we0_o, bus.occ_o, bus.stall_o, bus.ovf_o);
         end
      end
   endtask

   task automatic test_two_lane();
      bus.lane_vld_i = 4'b1010;
      set_lane(0, 7'h33, $urandom);
      set_lane(1, 7'h05, 32'h1000);
      set_lane(2, 7'h44, $urandom);
      set_lane(3, 7'h06, 32'h2000);
      tick();
      bus.lane_vld_i = '0;
      checks++;
      if (bus.occ_o !== 4'd2 || bus.we0_o !== 1'b1 || bus.addr0wr_o !== 7'h05 || bus.data0wr_o !== 32'h1000) begin
         failures++;
         $display("FAIL two_lane_first: occ=%0d we0=%b addr=%h data=%h required 2,1,05,00001000",
                  bus.occ_o, bus.we0_o, bus.addr0wr_o, bus.data0wr_o);
      end
      tick();
      checks++;
      if (bus.occ_o !== 4'd1 || bus.we0_o !== 1'b1 || bus.addr0wr_o !== 7'h06 || bus.data0wr_o !== 32'h2000) begin
         failures++;
         $display("FAIL two_lane_second: occ=%0d we0=%b addr=%h data=%h required 1,1,06,00002000",
                  bus.occ_o, bus.we0_o, bus.addr0wr_o, bus.data0wr_o);
      end
      tick();
      checks++;
      if (bus.occ_o !== 4'd0 || bus.we0_o !== 1'b0) begin
         failures++;
         $display("FAIL two_lane_empty: occ=%0d we0=%b required 0,0", bus.occ_o, bus.we0_o);
      end
   endtask

   task automatic test_full_rate();
      bit   seen_stall;
      ent_t e;
      seen_stall = 1'b0;
      d_stream.delete();
      m_stream.delete();
      sent.delete();
      for (int c = 0; c < 40; c++) begin
         bus.lane_vld_i = bus.stall_o ? 4'b0000 : 4'b1111;
         for (int i = 0; i < LANES; i++) begin
            e.a = INDEX'($urandom);
            e.d = $urandom;
            set_lane(i, e.a, e.d);
            if (bus.lane_vld_i[i]) sent.push_back(e);
         end
         tick();
         if (bus.stall_o === 1'b1) seen_stall = 1'b1;
         checks++;
         if (bus.occ_o !== CNTW'(mq.size()) || bus.stall_o !== ((DEPTH - mq.size()) < LANES)
             || bus.we0_o !== (mq.size() > 0)) begin
            failures++;
            $display("FAIL full_rate_ctl cycle %0d: occ=%0d stall=%b we0=%b required occ=%0d",
                     c, bus.occ_o, bus.stall_o, bus.we0_o, mq.size());
         end else if (mq.size() > 0 && (bus.addr0wr_o !== mq[0].a || bus.data0wr_o !== mq[0].d)) begin
            failures++;
            $display("FAIL full_rate_head cycle %0d: addr=%h data=%h required %h %h",
                     c, bus.addr0wr_o, bus.data0wr_o, mq[0].a, mq[0].d);
         end
      end
      drain();
      checks++;
      if (!seen_stall) begin
         failures++;
         $display("FAIL full_rate_stall: stall seen=0 required 1");
      end
      checks++;
      if (d_stream.size() != sent.size()) begin
         failures++;
         $display("FAIL full_rate_count: writes=%0d required %0d", d_stream.size(), sent.size());
      end else begin
         for (int k = 0; k < sent.size(); k++) begin
            if (d_stream[k] !== sent[k]) begin
               failures++;
               $display("FAIL full_rate_stream idx %0d: got %h required %h", k, d_stream[k], sent[k]);
               break;
            end
         end
      end
      checks++;
      if (bus.ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL full_rate_ovf: ovf=%b required 0", bus.ovf_o);
      end
   endtask

   task automatic test_overflow();
      ent_t e;
      d_stream.delete();
      sent.delete();
      bus.lane_vld_i = 4'b1111;
      for (int i = 0; i < LANES; i++) begin
         e.a = INDEX'(i + 16); e.d = 32'h100 + i; set_lane(i, e.a, e.d); sent.push_back(e);
      end
      tick();
      bus.lane_vld_i = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         e.a = INDEX'(i + 32); e.d = 32'h200 + i; set_lane(i, e.a, e.d); sent.push_back(e);
      end
      tick();
      checks++;
      if (bus.occ_o !== 4'd6 || bus.stall_o !== 1'b1) begin
         failures++;
         $display("FAIL ovf_setup: occ=%0d stall=%b required 6,1", bus.occ_o, bus.stall_o);
      end
      bus.lane_vld_i = 4'b0001;
      set_lane(0, 7'h7F, 32'hDEAD);
      tick();
      bus.lane_vld_i = '0;
      checks++;
      if (bus.ovf_o !== 1'b1 || bus.occ_o !== 4'd5) begin
         failures++;
         $display("FAIL ovf_set: ovf=%b occ=%0d required 1,5", bus.ovf_o, bus.occ_o);
      end
      drain();
      checks++;
      if (d_stream.size() != sent.size()) begin
         failures++;
         $display("FAIL ovf_stream_count: writes=%0d required %0d", d_stream.size(), sent.size());
      end else begin
         for (int k = 0; k < sent.size(); k++) begin
            if (d_stream[k] !== sent[k]) begin
               failures++;
               $display("FAIL ovf_stream idx %0d: got %h required %h", k, d_stream[k], sent[k]);
               break;
            end
         end
      end
      checks++;
      if (bus.ovf_o !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky: ovf=%b required 1", bus.ovf_o);
      end
   endtask

   task automatic test_flush();
      bus.lane_vld_i = 4'b1111;
      for (int i = 0; i < LANES; i++) set_lane(i, INDEX'(i + 48), $urandom);
      tick();
      bus.lane_vld_i = 4'b0011;
      tick();
      checks++;
      if (bus.occ_o !== 4'd5) begin
         failures++;
         $display("FAIL flush_setup: occ=%0d required 5", bus.occ_o);
      end
      bus.flush_i = 1'b1;
      bus.lane_vld_i = 4'b0011;
      set_lane(0, 7'h55, 32'h5555);
      set_lane(1, 7'h66, 32'h6666);
      tick();
      bus.flush_i = 1'b0;
      bus.lane_vld_i = '0;
      checks++;
      if (bus.occ_o !== 4'd0 || bus.we0_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_empty: occ=%0d we0=%b required 0,0", bus.occ_o, bus.we0_o);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (bus.we0_o !== 1'b0 || bus.occ_o !== CNTW'(mq.size())) begin
            failures++;
            $display("FAIL flush_idle cycle %0d: we0=%b occ=%0d required 0,0", c, bus.we0_o, bus.occ_o);
         end
      end
   endtask

   task automatic test_random();
      d_stream.delete();
      m_stream.delete();
      for (int c = 0; c < 300; c++) begin
         bus.lane_vld_i = bus.stall_o ? 4'b0000 : LANES'($urandom);
         bus.flush_i    = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < LANES; i++) set_lane(i, INDEX'($urandom_range(0, 15)), $urandom);
`ifdef ALNPC_WRQ_FWD_EN
         bus.rd_addr_i = INDEX'($urandom_range(0, 15));
         bus.rd_ram_i  = $urandom;
`endif
         tick();
         checks++;
         if (bus.occ_o !== CNTW'(mq.size()) || bus.stall_o !== ((DEPTH - mq.size()) < LANES)
             || bus.we0_o !== (mq.size() > 0)) begin
            failures++;
            $display("FAIL random_ctl cycle %0d: occ=%0d stall=%b we0=%b required occ=%0d",
                     c, bus.occ_o, bus.stall_o, bus.we0_o, mq.size());
         end else if (mq.size() > 0 && (bus.addr0wr_o !== mq[0].a || bus.data0wr_o !== mq[0].d)) begin
            failures++;
            $display("FAIL random_head cycle %0d: addr=%h data=%h required %h %h",
                     c, bus.addr0wr_o, bus.data0wr_o, mq[0].a, mq[0].d);
         end
`ifdef ALNPC_WRQ_FWD_EN
         begin
            logic [WIDTH-1:0] exp_d;
            logic             exp_h;
            exp_d = bus.rd_ram_i;
            exp_h = 1'b0;
            for (int k = mq.size() - 1; k >= 0; k--) begin
               if (mq[k].a == bus.rd_addr_i) begin
                  exp_d = mq[k].d; exp_h = 1'b1; break;
               end
            end
            checks++;
            if (bus.rd_data_o !== exp_d || bus.rd_hit_o !== exp_h) begin
               failures++;
               $display("FAIL random_fwd cycle %0d: data=%h hit=%b required %h %b",
                        c, bus.rd_data_o, bus.rd_hit_o, exp_d, exp_h);
            end
         end
`endif
      end
      drain();
      checks++;
      if (d_stream.size() != m_stream.size()) begin
         failures++;
         $display("FAIL random_stream_count: writes=%0d required %0d", d_stream.size(), m_stream.size());
      end else begin
         for (int k = 0; k < m_stream.size(); k++) begin
            if (d_stream[k] !== m_stream[k]) begin
               failures++;
               $display("FAIL random_stream idx %0d: got %h required %h", k, d_stream[k], m_stream[k]);
               break;
            end
         end
      end
   endtask

`ifdef ALNPC_WRQ_FWD_EN
   task automatic test_forward();
      bus.lane_vld_i = 4'b0011;
      set_lane(0, 7'h09, 32'hA0);
      set_lane(1, 7'h09, 32'hB0);
      tick();
      bus.lane_vld_i = '0;
      bus.rd_addr_i = 7'h09;
      bus.rd_ram_i  = 32'h11;
      #1;
      checks++;
      if (bus.rd_data_o !== 32'hB0 || bus.rd_hit_o !== 1'b1) begin
         failures++;
         $display("FAIL fwd_youngest: data=%h hit=%b required b0,1", bus.rd_data_o, bus.rd_hit_o);
      end
      tick();
      tick();
      checks++;
      if (bus.rd_data_o !== 32'h11 || bus.rd_hit_o !== 1'b0) begin
         failures++;
         $display("FAIL fwd_drained: data=%h hit=%b required 11,0", bus.rd_data_o, bus.rd_hit_o);
      end
   endtask
`endif

   task automatic test_reset_mid_drain();
      bus.lane_vld_i = 4'b1111;
      for (int i = 0; i < LANES; i++) set_lane(i, INDEX'(i), $urandom);
      tick();
      bus.lane_vld_i = '0;
      tick();
      #2;
      reset = 1'b0;
      #1;
      mq.delete();
      m_ovf = 1'b0;
      checks++;
      if (bus.we0_o !== 1'b0 || bus.occ_o !== '0 || bus.ovf_o !== 1'b0 || bus.stall_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_drain: we0=%b occ=%0d ovf=%b stall=%b required 0,0,0,0",
                  bus.we0_o, bus.occ_o, bus.ovf_o, bus.stall_o);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      checks++;
      if (bus.we0_o !== 1'b0 || bus.occ_o !== '0) begin
         failures++;
         $display("FAIL reset_release: we0=%b occ=%0d required 0,0", bus.we0_o, bus.occ_o);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_two_lane();
      test_full_rate();
      test_overflow();
      test_flush();
      test_random();
`ifdef ALNPC_WRQ_FWD_EN
      test_forward();
`endif
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
